rvc_decompress: RTL and testbench



---
 rtl/rvc_pkg.sv | 78 +++++++
 rtl/rvc_expand.sv | 127 ++++++++++++
 rtl/rvc_decompress.sv | 53 +++++
 tb/tb_rvc_decompress.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rvc_pkg.sv
// Shared RV32I/RV32C encoding constants and instruction-format builders
// used by the compressed-instruction expander.
package rvc_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_W   = 3'b010;
  localparam logic [2:0] F3_XOR = 3'b100;
  localparam logic [2:0] F3_SR  = 3'b101;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;
  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [1:0] {
    Q0     = 2'b00,
    Q1     = 2'b01,
    Q2     = 2'b10,
    Q_NONE = 2'b11
  } quadrant_e;

  localparam logic [2:0] C0_ADDI4SPN = 3'b000;
  localparam logic [2:0] C0_LW       = 3'b010;
  localparam logic [2:0] C0_SW       = 3'b110;
  localparam logic [2:0] C1_ADDI     = 3'b000;
  localparam logic [2:0] C1_JAL      = 3'b001;
  localparam logic [2:0] C1_LI       = 3'b010;
  localparam logic [2:0] C1_LUI      = 3'b011;
  localparam logic [2:0] C1_MISC     = 3'b100;
  localparam logic [2:0] C1_J        = 3'b101;
  localparam logic [2:0] C1_BEQZ     = 3'b110;
  localparam logic [2:0] C1_BNEZ     = 3'b111;
  localparam logic [2:0] C2_SLLI     = 3'b000;
  localparam logic [2:0] C2_LWSP     = 3'b010;
  localparam logic [2:0] C2_MISC     = 3'b100;
  localparam logic [2:0] C2_SWSP     = 3'b110;

  function automatic logic [4:0] creg(logic [2:0] r);
    return {2'b01, r};
  endfunction

  function automatic logic [31:0] enc_i(logic [11:0] imm, logic [4:0] rs1, logic [2:0] f3,
                                        logic [4:0] rd, logic [6:0] opc);
    return {imm, rs1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] enc_s(logic [11:0] imm, logic [4:0] rs2, logic [4:0] rs1,
                                        logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], OPC_STORE};
  endfunction

  function automatic logic [31:0] enc_b(logic [12:1] imm, logic [4:0] rs1, logic [2:0] f3);
    return {imm[12], imm[10:5], 5'd0, rs1, f3, imm[4:1], imm[11], OPC_BRANCH};
  endfunction

  function automatic logic [31:0] enc_j(logic [20:1] imm, logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, OPC_JAL};
  endfunction

  function automatic logic [31:0] enc_r(logic [6:0] f7, logic [4:0] rs2, logic [4:0] rs1,
                                        logic [2:0] f3, logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, OPC_OP};
  endfunction

endpackage

// File: rtl/rvc_expand.sv
// Combinational RV32C -> RV32I expander; flags illegal/reserved encodings
// and forces the expanded word to zero for them.
module rvc_expand
  import rvc_pkg::*;
(
  input  logic [15:0] i_c,
  output logic [31:0] o_instr,
  output logic        o_illegal
);

  logic [2:0]  w_f3;
  logic [4:0]  w_rd, w_rs2, w_r42, w_r97;
  logic [11:0] w_imm6, w_nzuimm, w_lwoff, w_sp16, w_lwspoff, w_swspoff;
  logic [12:1] w_boff;
  logic [20:1] w_joff;
  logic [31:0] w_ins;
  logic        w_ill;

  assign w_f3   = i_c[15:13];
  assign w_rd   = i_c[11:7];
  assign w_rs2  = i_c[6:2];
  assign w_r42  = creg(i_c[4:2]);
  assign w_r97  = creg(i_c[9:7]);
  assign w_imm6 = {{6{i_c[12]}}, i_c[12], i_c[6:2]};

  // Scattered immediate fields reassembled into natural bit order.
  assign w_nzuimm  = {2'b00, i_c[10:7], i_c[12:11], i_c[5], i_c[6], 2'b00};
  assign w_lwoff   = {5'b0, i_c[5], i_c[12:10], i_c[6], 2'b00};
  assign w_sp16    = {{3{i_c[12]}}, i_c[4:3], i_c[5], i_c[2], i_c[6], 4'b0};
  assign w_lwspoff = {4'b0, i_c[3:2], i_c[12], i_c[6:4], 2'b00};
  assign w_swspoff = {4'b0, i_c[8:7], i_c[12:9], 2'b00};
  assign w_boff    = {{5{i_c[12]}}, i_c[6:5], i_c[2], i_c[11:10], i_c[4:3]};
  assign w_joff    = {{10{i_c[12]}}, i_c[8], i_c[10:9], i_c[6], i_c[7], i_c[2], i_c[11], i_c[5:3]};

  always_comb begin
    w_ins = '0;
    w_ill = 1'b0;
    unique case (quadrant_e'(i_c[1:0]))
      Q0: begin
        case (w_f3)
          C0_ADDI4SPN: begin
            w_ill = (w_nzuimm == '0);
            w_ins = enc_i(w_nzuimm, 5'd2, F3_ADD, w_r42, OPC_OP_IMM);
          end
          C0_LW:   w_ins = enc_i(w_lwoff, w_r97, F3_W, w_r42, OPC_LOAD);
          C0_SW:   w_ins = enc_s(w_lwoff, w_r42, w_r97, F3_W);
          default: w_ill = 1'b1;
        endcase
      end
      Q1: begin
        case (w_f3)
          C1_ADDI: w_ins = enc_i(w_imm6, w_rd, F3_ADD, w_rd, OPC_OP_IMM);
          C1_JAL:  w_ins = enc_j(w_joff, 5'd1);
          C1_LI:   w_ins = enc_i(w_imm6, 5'd0, F3_ADD, w_rd, OPC_OP_IMM);
          C1_LUI: begin
            if (w_rd == 5'd2) begin
              w_ill = (w_sp16 == '0);
              w_ins = enc_i(w_sp16, 5'd2, F3_ADD, 5'd2, OPC_OP_IMM);
            end else begin
              w_ill = (w_rd != 5'd0) && (w_imm6 == '0);
              w_ins = {{8{w_imm6[11]}}, w_imm6, w_rd, OPC_LUI};
            end
          end
          C1_MISC: begin
            case (i_c[11:10])
              2'b00: begin
                w_ill = i_c[12];
                w_ins = enc_i({F7_BASE, i_c[6:2]}, w_r97, F3_SR, w_r97, OPC_OP_IMM);
              end
              2'b01: begin
                w_ill = i_c[12];
                w_ins = enc_i({F7_ALT, i_c[6:2]}, w_r97, F3_SR, w_r97, OPC_OP_IMM);
              end
              2'b10: w_ins = enc_i(w_imm6, w_r97, F3_AND, w_r97, OPC_OP_IMM);
              default: begin
                w_ill = i_c[12];
                case (i_c[6:5])
                  2'b00:   w_ins = enc_r(F7_ALT, w_r42, w_r97, F3_ADD, w_r97);
                  2'b01:   w_ins = enc_r(F7_BASE, w_r42, w_r97, F3_XOR, w_r97);
                  2'b10:   w_ins = enc_r(F7_BASE, w_r42, w_r97, F3_OR, w_r97);
                  default: w_ins = enc_r(F7_BASE, w_r42, w_r97, F3_AND, w_r97);
                endcase
              end
            endcase
          end
          C1_J:    w_ins = enc_j(w_joff, 5'd0);
          C1_BEQZ: w_ins = enc_b(w_boff, w_r97, F3_BEQ);
          default: w_ins = enc_b(w_boff, w_r97, F3_BNE);
        endcase
      end
      Q2: begin
        case (w_f3)
          C2_SLLI: begin
            w_ill = i_c[12];
            w_ins = enc_i({F7_BASE, i_c[6:2]}, w_rd, F3_SLL, w_rd, OPC_OP_IMM);
          end
          C2_LWSP: begin
            w_ill = (w_rd == 5'd0);
            w_ins = enc_i(w_lwspoff, 5'd2, F3_W, w_rd, OPC_LOAD);
          end
          C2_MISC: begin
            if (!i_c[12]) begin
              if (w_rs2 == 5'd0) begin
                w_ill = (w_rd == 5'd0);
                w_ins = enc_i('0, w_rd, F3_ADD, 5'd0, OPC_JALR);
              end else begin
                w_ins = enc_r(F7_BASE, w_rs2, 5'd0, F3_ADD, w_rd);
              end
            end else if (w_rs2 == 5'd0) begin
              if (w_rd == 5'd0) w_ins = enc_i(12'd1, 5'd0, F3_ADD, 5'd0, OPC_SYSTEM);
              else              w_ins = enc_i('0, w_rd, F3_ADD, 5'd1, OPC_JALR);
            end else begin
              w_ins = enc_r(F7_BASE, w_rs2, w_rd, F3_ADD, w_rd);
            end
          end
          C2_SWSP: w_ins = enc_s(w_swspoff, w_rs2, 5'd2, F3_W);
          default: w_ill = 1'b1;
        endcase
      end
      Q_NONE: w_ins = '0;
    endcase
  end

  assign o_illegal = w_ill;
  assign o_instr   = w_ill ? '0 : w_ins;

endmodule

// File: rtl/rvc_decompress.sv
// Registered RV32C expander: compressed words are expanded, 32-bit words pass
// through; one-cycle latency, outputs hold while no word is accepted.
module rvc_decompress
  import rvc_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] instr,
  output logic        out_valid,
  output logic [31:0] instr_out,
  output logic        is_compressed,
  output logic        illegal
);

  logic [31:0] w_exp;
  logic        w_exp_ill;
  logic        w_comp;
  logic        r_valid;
  logic [31:0] r_instr;
  logic        r_comp;
  logic        r_ill;

  rvc_expand u_expand (
    .i_c       (instr[15:0]),
    .o_instr   (w_exp),
    .o_illegal (w_exp_ill)
  );

  assign w_comp = (quadrant_e'(instr[1:0]) != Q_NONE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_valid <= 1'b0;
      r_instr <= '0;
      r_comp  <= 1'b0;
      r_ill   <= 1'b0;
    end else begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_instr <= w_comp ? w_exp : instr;
        r_comp  <= w_comp;
        r_ill   <= w_comp & w_exp_ill;
      end
    end
  end

  assign out_valid     = r_valid;
  assign instr_out     = r_instr;
  assign is_compressed = r_comp;
  assign illegal       = r_ill;

endmodule

// File: tb/tb_rvc_decompress.sv
// Bench for rvc_decompress: directed vectors plus random words against an
// integer-arithmetic model of the RV32C expansion rules.
module tb_rvc_decompress;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [31:0] instr;
  logic        out_valid;
  logic [31:0] instr_out;
  logic        is_compressed;
  logic        illegal;

  int n_cmp = 0;
  int n_bad = 0;

  logic        e_valid;
  logic [31:0] e_instr;
  logic        e_comp;
  logic        e_ill;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  rvc_decompress dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .instr         (instr),
    .out_valid     (out_valid),
    .instr_out     (instr_out),
    .is_compressed (is_compressed),
    .illegal       (illegal)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic int f(logic [15:0] h, int hi, int lo);
    return (int'(h) >> lo) & ((1 << (hi - lo + 1)) - 1);
  endfunction

  function automatic int sx(int v, int n);
    return (v >= (1 << (n - 1))) ? v - (1 << n) : v;
  endfunction

  function automatic logic [31:0] ti(int imm, int rs1, int f3, int rd, int op);
    return 32'(((imm & 'hfff) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op);
  endfunction

  function automatic logic [31:0] ts(int imm, int rs2, int rs1);
    return 32'((((imm >> 5) & 'h7f) << 25) | (rs2 << 20) | (rs1 << 15) | (2 << 12)
               | ((imm & 'h1f) << 7) | 'h23);
  endfunction

  function automatic logic [31:0] tb_(int imm, int rs1, int f3);
    return 32'((((imm >> 12) & 1) << 31) | (((imm >> 5) & 'h3f) << 25) | (rs1 << 15)
               | (f3 << 12) | (((imm >> 1) & 'hf) << 8) | (((imm >> 11) & 1) << 7) | 'h63);
  endfunction

  function automatic logic [31:0] tj(int imm, int rd);
    return 32'((((imm >> 20) & 1) << 31) | (((imm >> 1) & 'h3ff) << 21)
               | (((imm >> 11) & 1) << 20) | (((imm >> 12) & 'hff) << 12) | (rd << 7) | 'h6f);
  endfunction

  function automatic logic [31:0] tr(int f7, int rs2, int rs1, int f3, int rd);
    return 32'((f7 << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 'h33);
  endfunction

  // Returns {illegal, expanded word}.
  function automatic logic [32:0] ref_model(logic [31:0] w);
    logic [15:0] h;
    int q, f3, b12, rd, rs2, ra, rb, imm6, off;
    logic ill;
    logic [31:0] r;
    h = w[15:0];
    q = f(h, 1, 0);
    f3 = f(h, 15, 13);
    b12 = f(h, 12, 12);
    rd = f(h, 11, 7);
    rs2 = f(h, 6, 2);
    ra = 8 + f(h, 9, 7);
    rb = 8 + f(h, 4, 2);
    imm6 = sx(b12 * 32 + rs2, 6);
    ill = 1'b0;
    r = '0;
    if (q == 3) return {1'b0, w};
    if (q == 0) begin
      off = f(h, 5, 5) * 64 + f(h, 12, 10) * 8 + f(h, 6, 6) * 4;
      case (f3)
        0: begin
          off = f(h, 10, 7) * 64 + f(h, 12, 11) * 16 + f(h, 5, 5) * 8 + f(h, 6, 6) * 4;
          if (off == 0) ill = 1'b1;
          r = ti(off, 2, 0, rb, 'h13);
        end
        2: r = ti(off, ra, 2, rb, 'h03);
        6: r = ts(off, rb, ra);
        default: ill = 1'b1;
      endcase
    end else if (q == 1) begin
      case (f3)
        0: r = ti(imm6, rd, 0, rd, 'h13);
        1, 5: begin
          off = sx(b12 * 2048 + f(h, 8, 8) * 1024 + f(h, 10, 9) * 256 + f(h, 6, 6) * 128
                   + f(h, 7, 7) * 64 + f(h, 2, 2) * 32 + f(h, 11, 11) * 16 + f(h, 5, 3) * 2, 12);
          r = tj(off, (f3 == 1) ? 1 : 0);
        end
        2: r = ti(imm6, 0, 0, rd, 'h13);
        3: begin
          if (rd == 2) begin
            off = sx(b12 * 512 + f(h, 4, 3) * 128 + f(h, 5, 5) * 64 + f(h, 2, 2) * 32
                     + f(h, 6, 6) * 16, 10);
            if (off == 0) ill = 1'b1;
            r = ti(off, 2, 0, 2, 'h13);
          end else begin
            if (imm6 == 0 && rd != 0) ill = 1'b1;
            r = 32'(((imm6 & 'hfffff) << 12) | (rd << 7) | 'h37);
          end
        end
        4: begin
          case (f(h, 11, 10))
            0: begin if (b12 == 1) ill = 1'b1; r = ti(rs2, ra, 5, ra, 'h13); end
            1: begin if (b12 == 1) ill = 1'b1; r = ti(rs2 + 1024, ra, 5, ra, 'h13); end
            2: r = ti(imm6, ra, 7, ra, 'h13);
            default: begin
              if (b12 == 1) ill = 1'b1;
              case (f(h, 6, 5))
                0: r = tr(32, rb, ra, 0, ra);
                1: r = tr(0, rb, ra, 4, ra);
                2: r = tr(0, rb, ra, 6, ra);
                default: r = tr(0, rb, ra, 7, ra);
              endcase
            end
          endcase
        end
        default: begin
          off = sx(b12 * 256 + f(h, 6, 5) * 64 + f(h, 2, 2) * 32 + f(h, 11, 10) * 8
                   + f(h, 4, 3) * 2, 9);
          r = tb_(off, ra, (f3 == 6) ? 0 : 1);
        end
      endcase
    end else begin
      case (f3)
        0: begin if (b12 == 1) ill = 1'b1; r = ti(rs2, rd, 1, rd, 'h13); end
        2: begin
          if (rd == 0) ill = 1'b1;
          r = ti(f(h, 3, 2) * 64 + b12 * 32 + f(h, 6, 4) * 4, 2, 2, rd, 'h03);
        end
        4: begin
          if (b12 == 0 && rs2 == 0) begin
            if (rd == 0) ill = 1'b1;
            r = ti(0, rd, 0, 0, 'h67);
          end else if (b12 == 0) r = tr(0, rs2, 0, 0, rd);
          else if (rs2 == 0 && rd == 0) r = 32'h0010_0073;
          else if (rs2 == 0) r = ti(0, rd, 0, 1, 'h67);
          else r = tr(0, rs2, rd, 0, rd);
        end
        6: r = ts(f(h, 8, 7) * 64 + f(h, 12, 9) * 4, rs2, 2);
        default: ill = 1'b1;
      endcase
    end
    return ill ? {1'b1, 32'h0} : {1'b0, r};
  endfunction

  task automatic step(input logic r, input logic v, input logic [31:0] w, input string tag);
    logic [32:0] m;
    rst = r;
    in_valid = v;
    instr = w;
    @(posedge clk);
    #1;
    m = ref_model(w);
    if (!r) begin
      e_valid = 1'b0; e_instr = '0; e_comp = 1'b0; e_ill = 1'b0;
    end else begin
      e_valid = v;
      if (v) begin
        e_comp = (w[1:0] != 2'b11);
        e_ill = m[32];
        e_instr = m[31:0];
      end
    end
    check({tag, ".out_valid"}, 32'(out_valid), 32'(e_valid));
    check({tag, ".instr_out"}, instr_out, e_instr);
    check({tag, ".is_compressed"}, 32'(is_compressed), 32'(e_comp));
    check({tag, ".illegal"}, 32'(illegal), 32'(e_ill));
  endtask

  typedef struct {
    logic [31:0] w;
    logic [31:0] exp_out;
    logic        exp_comp;
    logic        exp_ill;
  } vec_t;

  vec_t plan[6];

  initial begin
    rst = 1'b0;
    in_valid = 1'b0;
    instr = '0;
    e_valid = 1'b0; e_instr = '0; e_comp = 1'b0; e_ill = 1'b0;

    plan[0] = '{32'h0000_4501, 32'h0000_0513, 1'b1, 1'b0};
    plan[1] = '{32'h0000_8082, 32'h0000_8067, 1'b1, 1'b0};
    plan[2] = '{32'h0000_0040, 32'h0041_0413, 1'b1, 1'b0};
    plan[3] = '{32'h0000_BFFD, 32'hFFFF_F06F, 1'b1, 1'b0};
    plan[4] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 1'b1};
    plan[5] = '{32'h00A0_0093, 32'h00A0_0093, 1'b0, 1'b0};

    step(1'b0, 1'b1, 32'h0000_4501, "reset_with_valid");
    step(1'b0, 1'b0, 32'h0000_8082, "reset_idle");

    foreach (plan[i]) begin
      step(1'b1, 1'b1, plan[i].w, $sformatf("plan%0d", i));
      check($sformatf("plan%0d.word", i), instr_out, plan[i].exp_out);
      check($sformatf("plan%0d.comp", i), 32'(is_compressed), 32'(plan[i].exp_comp));
      check($sformatf("plan%0d.ill", i), 32'(illegal), 32'(plan[i].exp_ill));
    end

    step(1'b1, 1'b0, 32'h0000_4501, "hold");
    check("hold.word", instr_out, 32'h00A0_0093);
    step(1'b1, 1'b1, 32'h0000_8082, "pre_reset");
    step(1'b0, 1'b1, 32'h0000_4501, "reset_mid");
    check("reset_mid.word", instr_out, 32'h0);

    for (int n = 0; n < 1500; n++) begin
      logic [31:0] w;
      logic v, r;
      w = $urandom;
      if ($urandom_range(0, 5) != 0) w[1:0] = 2'($urandom_range(0, 2));
      v = ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 49) != 0);
      step(r, v, w, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
